oddeven_sort_engine: RTL and testbench
======================================

Name: oddeven_sort_engine

Overview:
- Parametrised multi-cycle sorting engine for the median filter datapath; successor to the fixed 9-entry, one-compare-per-cycle sorter.
- Sorts a vector of N unsigned samples using odd-even transposition. Each cycle runs every disjoint compare-exchange of the current phase in parallel, so a full sort takes N cycles instead of about N²/2.
- Supports a runtime ascending/descending order select and a direct median output.
- Sits between the window buffer and the pixel output stage.

Parameters:
- DATA_W, 8: bit width of each unsigned sample.
- N, 9: number of samples. Must be odd and at least 3; an elaboration error fires otherwise.
- PH_W, $clog2(N+1): width of the phase counter. Derived; never overridden.

Ports:
- CLK  in  1: clock.
- RST  in  1: reset, asynchronous, active-low.
- start_i  in  1: request to sort. Sampled only when ready_o=1.
- order_i  in  1: 0 = ascending, 1 = descending. Captured together with data_i.
- data_i  in  N*DATA_W: input samples. Element i is at [i*DATA_W +: DATA_W].
- ready_o  out  1: engine is IDLE and will accept start_i.
- valid_o  out  1: one-cycle pulse; data_o and median_o hold the sorted result.
- data_o  out  N*DATA_W: working/result registers, same packing as data_i.
- median_o  out  DATA_W: element (N-1)/2 of data_o.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, phase counter=0, all data registers=0, stored order=0.
  - Outputs: ready_o=1, valid_o=0, data_o=0, median_o=0.
  - Reset asserted mid-sort aborts the sort immediately. No valid_o is produced for that request.
- States:
  - IDLE: ready_o=1. If start_i=1 at edge k, capture data_i and order_i, set phase=0, go to SORT. Otherwise stay.
  - SORT: ready_o=0. Each edge applies phase p, then increments p. When the edge applies p=N-1, go to DONE.
  - DONE: valid_o=1 for exactly one cycle, then unconditionally go to IDLE.
  - Unused state encoding: go to IDLE; data registers hold their value.
- Phase p compare pairs:
  - p even: pairs (0,1), (2,3) ... (N-3,N-2). Element N-1 is untouched.
  - p odd: pairs (1,2), (3,4) ... (N-2,N-1). Element 0 is untouched.
- Compare-exchange rule:
  - Ascending: swap when lower-index value > higher-index value.
  - Descending: swap when lower-index value < higher-index value.
  - Equal values never swap.
  - Comparison is unsigned and DATA_W wide; no extension.
- Latency: start_i is accepted at edge k and valid_o is high in the cycle after edge k+N. Registers update only in SORT.
- Hold behaviour: data_o and median_o hold the last result through DONE and IDLE until the next accepted start_i overwrites them.
- start_i while ready_o=0 is ignored; it is not queued.
- start_i held high continuously: IDLE after DONE accepts a new request, so throughput is one sort every N+2 cycles.
- order_i and data_i changes during SORT have no effect.
- median_o is combinational from the data registers. It is valid-qualified only by valid_o.

Optional Feature:
- Macro: OES_EARLY_EXIT_EN.
- Defined:
  - A one-bit register swap_seen_r records whether the previous phase performed any swap.
  - If the current phase performs no swap, p>=1, and the previous phase also performed no swap, go to DONE after the current edge.
  - Minimum sort latency is 2 cycles (already-sorted input); maximum is N.
  - swap_seen_r resets to 0 and is cleared on capture.
- Undefined: no swap tracking logic; latency is fixed at N.
- Sorted results are identical in both builds.

Test Plan:
- Ascending, N=9, DATA_W=8, data_i elements 0..8 = {9,3,7,1,8,2,6,4,5}, start at edge k → valid_o pulse in the cycle after edge k+9, data_o = {1..9}, median_o=5, ready_o=0 from edge k until edge k+10.
- Descending, same data, order_i=1 → data_o = {9,8,...,1}, median_o=5.
- Duplicates and extremes, elements {255,0,255,0,128,128,0,255,128} ascending → {0,0,0,128,128,128,255,255,255}, median_o=128. Also check the same input descending.
- start_i re-pulsed with new data during SORT → ignored; result matches the first request; exactly one valid_o pulse.
- RST asserted low mid-SORT at phase 4 → next cycle: data_o=0, ready_o=1, no valid_o. A fresh start then sorts correctly.
- Parametrisation N=5, DATA_W=12, elements {4095,17,2048,0,17} → {0,17,17,2048,4095}, median_o=17, valid_o 5 cycles after the start edge. With OES_EARLY_EXIT_EN and pre-sorted input {1,2,3,4,5}, valid_o comes 2 cycles after the start edge.

Source files
------------

// File: rtl/oddeven_sort_engine.sv
// rtl/oddeven_sort_engine.sv - odd-even transposition sorter with order select and median tap
// Optional early exit on two consecutive swap-free phases: OES_EARLY_EXIT_EN
module oddeven_sort_engine #(
    parameter int DATA_W = 8,
    parameter int N      = 9,
    parameter int PH_W   = $clog2(N + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_i,
    input  logic                order_i,
    input  logic [N*DATA_W-1:0] data_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [N*DATA_W-1:0] data_o,
    output logic [DATA_W-1:0]   median_o
);

    if ((N % 2) == 0 || N < 3) begin : g_bad_n
        $error("oddeven_sort_engine: N must be odd and at least 3");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PH_W-1:0]   phase;
    logic [DATA_W-1:0] mem    [N];
    logic [DATA_W-1:0] mem_nx [N];
    logic              order_r;
    logic              load;
    logic              step;
    logic              last_phase;
    logic              early;

`ifdef OES_EARLY_EXIT_EN
    logic any_swap;
    logic swap_seen_r;
`endif

    // Pairs of one phase are disjoint, so every exchange reads the pre-phase values.
    always_comb begin
`ifdef OES_EARLY_EXIT_EN
        any_swap = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            mem_nx[i] = mem[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == phase[0]) begin
                if (order_r ? (mem[i] < mem[i+1]) : (mem[i] > mem[i+1])) begin
                    mem_nx[i]   = mem[i+1];
                    mem_nx[i+1] = mem[i];
`ifdef OES_EARLY_EXIT_EN
                    any_swap    = 1'b1;
`endif
                end
            end
        end
    end

    assign last_phase = (phase == PH_W'(N - 1));

`ifdef OES_EARLY_EXIT_EN
    assign early = !any_swap && (phase != '0) && !swap_seen_r;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            swap_seen_r <= 1'b0;
        end else if (load) begin
            swap_seen_r <= 1'b0;
        end else if (step) begin
            swap_seen_r <= any_swap;
        end
    end
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load     = 1'b1;
                    state_nx = S_SORT;
                end
            end
            S_SORT: begin
                step = 1'b1;
                if (last_phase || early) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                valid_o  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase   <= '0;
            order_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            phase   <= '0;
            order_r <= order_i;
            for (int i = 0; i < N; i++) begin
                mem[i] <= data_i[i*DATA_W +: DATA_W];
            end
        end else if (step) begin
            phase <= phase + PH_W'(1);
            for (int i = 0; i < N; i++) begin
                mem[i] <= mem_nx[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_o[i*DATA_W +: DATA_W] = mem[i];
        end
    end

    assign median_o = mem[(N - 1) / 2];

endmodule

// File: tb/tb_oddeven_sort_engine.sv
// tb/tb_oddeven_sort_engine.sv - directed and random checks of oddeven_sort_engine against a sorting model
module tb_oddeven_sort_engine;

    localparam int N9 = 9;
    localparam int W9 = 8;
    localparam int N5 = 5;
    localparam int W5 = 12;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start9, order9, ready9, valid9;
    logic [71:0] data9, dout9;
    logic [7:0]  med9;
    logic        start5, order5, ready5, valid5;
    logic [59:0] data5, dout5;
    logic [11:0] med5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    oddeven_sort_engine #(.DATA_W(W9), .N(N9)) u_dut9 (
        .CLK(CLK), .RST(RST), .start_i(start9), .order_i(order9), .data_i(data9),
        .ready_o(ready9), .valid_o(valid9), .data_o(dout9), .median_o(med9)
    );

    oddeven_sort_engine #(.DATA_W(W5), .N(N5)) u_dut5 (
        .CLK(CLK), .RST(RST), .start_i(start5), .order_i(order5), .data_i(data5),
        .ready_o(ready5), .valid_o(valid5), .data_o(dout5), .median_o(med5)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] elem(input logic [127:0] v, input int i, input int w);
        return (v >> (i * w)) & ((128'd1 << w) - 128'd1);
    endfunction

    // Reference: plain insertion sort of the unpacked elements.
    function automatic logic [127:0] sort_ref(input logic [127:0] v, input int n, input int w, input bit desc);
        int a[16];
        int t;
        int j;
        logic [127:0] r;
        for (int i = 0; i < n; i++) a[i] = int'(elem(v, i, w));
        for (int i = 1; i < n; i++) begin
            t = a[i];
            j = i - 1;
            while (j >= 0 && (desc ? (a[j] < t) : (a[j] > t))) begin
                a[j+1] = a[j];
                j--;
            end
            a[j+1] = t;
        end
        r = '0;
        for (int i = 0; i < n; i++) r |= 128'(a[i]) << (i * w);
        return r;
    endfunction

    task automatic run9(input logic [71:0] din, input logic ord, input bit repulse,
                        input bit presorted, input string tag);
        logic [127:0] exp;
        logic [71:0]  got;
        logic [7:0]   gotm;
        logic         rdy_at_valid, rdy_after;
        int           lat, pulses;
        exp = sort_ref(128'(din), N9, W9, ord);
        for (int c = 0; c < 40 && ready9 !== 1'b1; c++) @(negedge CLK);
        check({tag, " ready_before"}, 128'(ready9), 128'd1);
        @(negedge CLK);
        start9 = 1'b1; data9 = din; order9 = ord;
        @(posedge CLK); #1;
        start9 = 1'b0; data9 = ~din; order9 = ~ord;
        check({tag, " ready_low"}, 128'(ready9), 128'd0);
        lat = -1; pulses = 0; got = 'x; gotm = 'x; rdy_at_valid = 1'bx; rdy_after = 1'bx;
        for (int j = 1; j <= N9 + 4; j++) begin
            if (repulse && j == 3) begin
                start9 = 1'b1; data9 = {9{8'hA5}}; order9 = ~ord;
            end
            if (repulse && j == 4) start9 = 1'b0;
            @(posedge CLK); #1;
            if (lat > 0 && j == lat + 1) rdy_after = ready9;
            if (valid9 === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = j; got = dout9; gotm = med9; rdy_at_valid = ready9;
                end
            end
        end
        check({tag, " pulses"}, 128'(pulses), 128'd1);
        check({tag, " data"}, 128'(got), exp);
        check({tag, " median"}, 128'(gotm), elem(exp, (N9 - 1) / 2, W9));
        check({tag, " ready_at_valid"}, 128'(rdy_at_valid), 128'd0);
        check({tag, " ready_after"}, 128'(rdy_after), 128'd1);
        check({tag, " hold"}, 128'(dout9), exp);
`ifdef OES_EARLY_EXIT_EN
        if (presorted) check({tag, " latency"}, 128'(lat), 128'd2);
        else check({tag, " latency_range"}, 128'(lat >= 2 && lat <= N9), 128'd1);
`else
        check({tag, " latency"}, 128'(lat), 128'(N9));
`endif
    endtask

    task automatic run5(input logic [59:0] din, input logic ord, input bit presorted, input string tag);
        logic [127:0] exp;
        logic [59:0]  got;
        logic [11:0]  gotm;
        int           lat, pulses;
        exp = sort_ref(128'(din), N5, W5, ord);
        @(negedge CLK);
        start5 = 1'b1; data5 = din; order5 = ord;
        @(posedge CLK); #1;
        start5 = 1'b0; data5 = '0;
        lat = -1; pulses = 0; got = 'x; gotm = 'x;
        for (int j = 1; j <= N5 + 4; j++) begin
            @(posedge CLK); #1;
            if (valid5 === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = j; got = dout5; gotm = med5;
                end
            end
        end
        check({tag, " pulses"}, 128'(pulses), 128'd1);
        check({tag, " data"}, 128'(got), exp);
        check({tag, " median"}, 128'(gotm), elem(exp, (N5 - 1) / 2, W5));
`ifdef OES_EARLY_EXIT_EN
        if (presorted) check({tag, " latency"}, 128'(lat), 128'd2);
        else check({tag, " latency_range"}, 128'(lat >= 2 && lat <= N5), 128'd1);
`else
        check({tag, " latency"}, 128'(lat), 128'(N5));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] vec1, dup, rev, asc9, rnd;
        int pulses;
        vec1 = {8'd5, 8'd4, 8'd6, 8'd2, 8'd8, 8'd1, 8'd7, 8'd3, 8'd9};
        dup  = {8'd128, 8'd255, 8'd0, 8'd128, 8'd128, 8'd0, 8'd255, 8'd0, 8'd255};
        rev  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        asc9 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

        RST = 1'b0;
        start9 = 1'b0; order9 = 1'b0; data9 = '0;
        start5 = 1'b0; order5 = 1'b0; data5 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst data", 128'(dout9), 128'd0);
        check("rst median", 128'(med9), 128'd0);
        check("rst ready", 128'(ready9), 128'd1);
        check("rst valid", 128'(valid9), 128'd0);
        check("rst data5", 128'(dout5), 128'd0);
        RST = 1'b1;

        run9(vec1, 1'b0, 1'b0, 1'b0, "asc");
        run9(vec1, 1'b1, 1'b0, 1'b0, "desc");
        run9(dup, 1'b0, 1'b0, 1'b0, "dup_asc");
        run9(dup, 1'b1, 1'b0, 1'b0, "dup_desc");
        run9(vec1, 1'b0, 1'b1, 1'b0, "repulse");

        // Abort a sort with reset after four phases have been applied.
        @(negedge CLK);
        start9 = 1'b1; data9 = rev; order9 = 1'b0;
        @(posedge CLK); #1;
        start9 = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midrst data", 128'(dout9), 128'd0);
        check("midrst median", 128'(med9), 128'd0);
        check("midrst ready", 128'(ready9), 128'd1);
        check("midrst valid", 128'(valid9), 128'd0);
        @(negedge CLK);
        RST = 1'b1;
        pulses = 0;
        for (int j = 0; j < N9 + 4; j++) begin
            @(posedge CLK); #1;
            if (valid9 === 1'b1) pulses++;
        end
        check("midrst no_valid", 128'(pulses), 128'd0);

        run9(rev, 1'b0, 1'b0, 1'b0, "post_rst");
        run9(asc9, 1'b0, 1'b0, 1'b1, "presorted");

        for (int k = 0; k < 8; k++) begin
            rnd = {$urandom, $urandom, $urandom};
            run9(rnd, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "random");
        end

        run5({12'd17, 12'd0, 12'd2048, 12'd17, 12'd4095}, 1'b0, 1'b0, "n5_asc");
        run5({12'd5, 12'd4, 12'd3, 12'd2, 12'd1}, 1'b0, 1'b1, "n5_presorted");
        run5({12'd17, 12'd0, 12'd2048, 12'd17, 12'd4095}, 1'b1, 1'b0, "n5_desc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
